// File: rtl/branch_predict_resolve_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types, funct3 encodings and saturating-counter helpers
//                for the branch prediction / resolution unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Conditional-branch condition encodings (RV32I funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 2-bit direction counter; the MSB is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    function automatic bht_cnt_t sat_inc(input bht_cnt_t c);
        return (c == ST) ? ST : bht_cnt_t'(c + 2'd1);
    endfunction

    function automatic bht_cnt_t sat_dec(input bht_cnt_t c);
        return (c == SNT) ? SNT : bht_cnt_t'(c - 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_resolve_if
//  Description : Fetch-lookup, EX-resolve, redirect and statistics signals of
//                the branch unit. Signal names are as seen from the unit:
//                i_* flow into it, o_* flow out of it.
//                slave  - the branch unit
//                master - the surrounding pipeline
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predict_resolve_if #(
    parameter int XLEN   = 32,
    parameter int STAT_W = 32
);
    logic [XLEN-1:0]   i_if_pc;
    logic              o_if_pred_taken;
    logic              i_ex_valid;
    logic              i_ex_branch;
    logic              i_ex_jump;
    logic [2:0]        i_ex_funct3;
    logic              i_ex_eq;
    logic              i_ex_lt;
    logic              i_ex_ltu;
    logic [XLEN-1:0]   i_ex_pc;
    logic              i_ex_pred_taken;
    logic [XLEN-1:0]   i_ex_target;
    logic              o_ex_taken;
    logic              o_ex_illegal;
    logic              o_redirect_valid;
    logic [XLEN-1:0]   o_redirect_pc;
    logic [STAT_W-1:0] o_br_count;
    logic [STAT_W-1:0] o_mp_count;

    modport slave (
        input  i_if_pc, i_ex_valid, i_ex_branch, i_ex_jump, i_ex_funct3,
               i_ex_eq, i_ex_lt, i_ex_ltu, i_ex_pc, i_ex_pred_taken, i_ex_target,
        output o_if_pred_taken, o_ex_taken, o_ex_illegal, o_redirect_valid,
               o_redirect_pc, o_br_count, o_mp_count
    );

    modport master (
        output i_if_pc, i_ex_valid, i_ex_branch, i_ex_jump, i_ex_funct3,
               i_ex_eq, i_ex_lt, i_ex_ltu, i_ex_pc, i_ex_pred_taken, i_ex_target,
        input  o_if_pred_taken, o_ex_taken, o_ex_illegal, o_redirect_valid,
               o_redirect_pc, o_br_count, o_mp_count
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module      : branch_history_table
//  Description : Table of 2-bit saturating direction counters.
//                i_rd_idx/o_rd_cnt    - asynchronous lookup port
//                i_upd_en/idx/taken   - synchronous training port; the counter
//                                       at i_upd_idx moves toward i_upd_taken
//                i_clk/i_rst          - clock, sync active-high reset (all WNT)
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_history_table
    import branch_pkg::*;
#(
    parameter  int BHT_ENTRIES = 64,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    input  wire logic [IDX_W-1:0] i_rd_idx,
    output bht_cnt_t              o_rd_cnt,
    input  wire logic             i_upd_en,
    input  wire logic [IDX_W-1:0] i_upd_idx,
    input  wire logic             i_upd_taken
);
    bht_cnt_t r_table [BHT_ENTRIES];
    bht_cnt_t w_upd_cur;
    bht_cnt_t w_upd_nxt;

    // Lookup sees the stored value only; a same-cycle update is not bypassed.
    assign o_rd_cnt  = r_table[i_rd_idx];
    assign w_upd_cur = r_table[i_upd_idx];
    assign w_upd_nxt = i_upd_taken ? sat_inc(w_upd_cur) : sat_dec(w_upd_cur);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_table[i] <= WNT;
            end
        end else if (i_upd_en) begin
            r_table[i_upd_idx] <= w_upd_nxt;
        end
    end
endmodule
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_resolve
//  Description : Branch/jump resolution with a 2-bit counter direction
//                predictor, registered one-cycle redirect and saturating
//                branch / mispredict statistics.
//                i_clk, i_rst - clock, synchronous active-high reset
//                bus (slave)  - fetch lookup, EX resolve inputs, resolved
//                               direction, redirect and statistics outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int STAT_W      = 32
) (
    input wire logic           i_clk,
    input wire logic           i_rst,
    branch_predict_resolve_if.slave bus
);
    localparam int                IDX_W      = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0]   c_pc_step  = XLEN'(4);
    localparam logic [STAT_W-1:0] c_stat_max = '1;

    logic              w_acc;
    logic              w_ctl;
    logic              w_taken;
    logic              w_illegal;
    logic              w_mispredict;
    logic              w_train;
    logic [XLEN-1:0]   w_redirect_pc;
    bht_cnt_t          w_if_cnt;
    logic              r_redirect_valid;
    logic [XLEN-1:0]   r_redirect_pc;
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mp_count;

    // The instruction sitting in EX during a redirect is wrong-path.
    assign w_acc = bus.i_ex_valid & ~r_redirect_valid;

    // Branch decode wins over jump when both are flagged.
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        if (w_acc && bus.i_ex_branch) begin
            case (bus.i_ex_funct3)
                F3_BEQ:  w_taken = bus.i_ex_eq;
                F3_BNE:  w_taken = ~bus.i_ex_eq;
                F3_BLT:  w_taken = bus.i_ex_lt;
                F3_BGE:  w_taken = ~bus.i_ex_lt;
                F3_BLTU: w_taken = bus.i_ex_ltu;
                F3_BGEU: w_taken = ~bus.i_ex_ltu;
                default: w_illegal = 1'b1;
            endcase
        end else if (w_acc && bus.i_ex_jump) begin
            w_taken = 1'b1;
        end
    end

    assign w_ctl         = w_acc & (bus.i_ex_branch | bus.i_ex_jump);
    assign w_mispredict  = w_ctl & (w_taken != bus.i_ex_pred_taken);
    assign w_train       = w_acc & bus.i_ex_branch & ~w_illegal;
    assign w_redirect_pc = w_taken ? bus.i_ex_target : (bus.i_ex_pc + c_pc_step);

    branch_history_table #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (bus.i_if_pc[IDX_W+1:2]),
        .o_rd_cnt    (w_if_cnt),
        .i_upd_en    (w_train),
        .i_upd_idx   (bus.i_ex_pc[IDX_W+1:2]),
        .i_upd_taken (w_taken)
    );

    // A redirect lasts one cycle; it also blocks acceptance in that cycle, so
    // two redirects can never be adjacent.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) begin
                r_redirect_pc <= w_redirect_pc;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (w_ctl && (r_br_count != c_stat_max)) begin
                r_br_count <= r_br_count + STAT_W'(1);
            end
            if (w_mispredict && (r_mp_count != c_stat_max)) begin
                r_mp_count <= r_mp_count + STAT_W'(1);
            end
        end
    end

    assign bus.o_if_pred_taken  = w_if_cnt[1];
    assign bus.o_ex_taken       = w_taken;
    assign bus.o_ex_illegal     = w_illegal;
    assign bus.o_redirect_valid = r_redirect_valid;
    assign bus.o_redirect_pc    = r_redirect_pc;
    assign bus.o_br_count       = r_br_count;
    assign bus.o_mp_count       = r_mp_count;
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predict_resolve
//  Description : Self-checking bench for branch_predict_resolve. A 64-entry
//                instance runs directed and random sequences against a
//                behavioural model with a redirect scoreboard; a STAT_W=3
//                instance exercises statistic saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    branch_predict_resolve_if #(.XLEN(32), .STAT_W(32)) bus  ();
    branch_predict_resolve_if #(.XLEN(32), .STAT_W(3))  bus2 ();

    branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(64), .STAT_W(32)) u_dut (
        .i_clk (clk), .i_rst (rst), .bus (bus.slave)
    );
    branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(4), .STAT_W(3)) u_dut2 (
        .i_clk (clk), .i_rst (rst2), .bus (bus2.slave)
    );

    // Expected direction per funct3: bit k of taken_mask is the outcome for
    // flags {eq,lt,ltu} == k.
    typedef struct {
        logic [2:0] f3;
        logic [7:0] taken_mask;
        logic       illegal;
    } vec_t;
    vec_t vecs [8];

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic        chk;
    } rd_t;
    rd_t sb [$];

    logic [1:0] m_bht [64];
    int         m_br;
    int         m_mp;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_br = 0;
        m_mp = 0;
        sb.delete();
        sb.push_back('{v: 1'b0, pc: 32'h0, chk: 1'b1});
    endtask

    task automatic drive_idle();
        bus.i_ex_valid = 0; bus.i_ex_branch = 0; bus.i_ex_jump = 0;
        bus.i_ex_funct3 = 0; bus.i_ex_eq = 0; bus.i_ex_lt = 0; bus.i_ex_ltu = 0;
        bus.i_ex_pc = 0; bus.i_ex_pred_taken = 0; bus.i_ex_target = 0; bus.i_if_pc = 0;
    endtask

    // One cycle on the main instance: drive, check at negedge, advance model.
    task automatic step(input logic v, input logic br, input logic jmp,
                        input logic [2:0] f3, input logic [2:0] flags,
                        input logic [31:0] pc, input logic pred,
                        input logic [31:0] tgt, input logic [31:0] ifpc);
        rd_t  exp_rd;
        logic acc, tk, il, mp;
        logic [5:0] ei;
        bus.i_ex_valid = v;  bus.i_ex_branch = br; bus.i_ex_jump = jmp;
        bus.i_ex_funct3 = f3;
        bus.i_ex_eq = flags[2]; bus.i_ex_lt = flags[1]; bus.i_ex_ltu = flags[0];
        bus.i_ex_pc = pc; bus.i_ex_pred_taken = pred; bus.i_ex_target = tgt;
        bus.i_if_pc = ifpc;
        @(negedge clk);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            exp_rd = '0;
        end else begin
            exp_rd = sb.pop_front();
        end
        check("redirect_valid", {31'd0, bus.o_redirect_valid}, {31'd0, exp_rd.v});
        if (exp_rd.chk) check("redirect_pc", bus.o_redirect_pc, exp_rd.pc);
        check("br_count", bus.o_br_count, 32'(m_br));
        check("mp_count", bus.o_mp_count, 32'(m_mp));
        acc = v && !exp_rd.v;
        tk = 1'b0;
        il = 1'b0;
        if (acc && br) begin
            tk = vecs[f3].taken_mask[flags];
            il = vecs[f3].illegal;
        end else if (acc && jmp) begin
            tk = 1'b1;
        end
        check("ex_taken", {31'd0, bus.o_ex_taken}, {31'd0, tk});
        check("ex_illegal", {31'd0, bus.o_ex_illegal}, {31'd0, il});
        check("if_pred_taken", {31'd0, bus.o_if_pred_taken}, {31'd0, m_bht[ifpc[7:2]][1]});
        mp = acc && (br || jmp) && (tk != pred);
        sb.push_back('{v: mp, pc: (tk ? tgt : pc + 32'd4), chk: mp});
        if (acc && (br || jmp)) m_br++;
        if (mp) m_mp++;
        if (acc && br && !il) begin
            ei = pc[7:2];
            if (tk) m_bht[ei] = (m_bht[ei] == 2'b11) ? 2'b11 : m_bht[ei] + 2'b01;
            else    m_bht[ei] = (m_bht[ei] == 2'b00) ? 2'b00 : m_bht[ei] - 2'b01;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, ifpc);
    endtask

    initial begin
        vecs[0] = '{f3: F3_BEQ,  taken_mask: 8'hF0, illegal: 1'b0};
        vecs[1] = '{f3: F3_BNE,  taken_mask: 8'h0F, illegal: 1'b0};
        vecs[2] = '{f3: 3'b010,  taken_mask: 8'h00, illegal: 1'b1};
        vecs[3] = '{f3: 3'b011,  taken_mask: 8'h00, illegal: 1'b1};
        vecs[4] = '{f3: F3_BLT,  taken_mask: 8'hCC, illegal: 1'b0};
        vecs[5] = '{f3: F3_BGE,  taken_mask: 8'h33, illegal: 1'b0};
        vecs[6] = '{f3: F3_BLTU, taken_mask: 8'hAA, illegal: 1'b0};
        vecs[7] = '{f3: F3_BGEU, taken_mask: 8'h55, illegal: 1'b0};

        drive_idle();
        bus2.i_ex_valid = 0; bus2.i_ex_branch = 0; bus2.i_ex_jump = 0;
        bus2.i_ex_funct3 = 0; bus2.i_ex_eq = 0; bus2.i_ex_lt = 0; bus2.i_ex_ltu = 0;
        bus2.i_ex_pc = 0; bus2.i_ex_pred_taken = 0; bus2.i_ex_target = 0; bus2.i_if_pc = 0;
        rst = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rst2 = 1'b0;
        model_reset();

        // Reset state, lookups at assorted PCs
        idle(32'h0000_0000);
        idle(32'h0000_0100);
        idle(32'hFFFF_FFFC);

        // First mispredict: BEQ taken, predicted not-taken
        step(1, 1, 0, F3_BEQ, 3'b100, 32'h100, 0, 32'h200, 32'h100);
        idle(32'h100);

        // Training at 0x40 (the lookup in each EX cycle sees the pre-update value)
        step(1, 1, 0, F3_BEQ, 3'b100, 32'h40, 0, 32'h80, 32'h40);
        idle(32'h40);
        step(1, 1, 0, F3_BEQ, 3'b100, 32'h40, 1, 32'h80, 32'h40);
        step(1, 1, 0, F3_BEQ, 3'b100, 32'h40, 1, 32'h80, 32'h40);
        step(1, 1, 0, F3_BEQ, 3'b000, 32'h40, 1, 32'h80, 32'h40);
        idle(32'h40);

        // Illegal funct3 on a weak-taken entry must not train it
        step(1, 1, 0, 3'b010, 3'b100, 32'h40, 0, 32'h80, 32'h40);
        step(1, 1, 0, 3'b011, 3'b111, 32'h40, 0, 32'h80, 32'h40);
        idle(32'h40);

        // Full funct3 x flag table, predicted correctly so no redirects
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 8; k++) begin
                logic [31:0] vpc;
                vpc = 32'h2000 + (32'(f * 8 + k) << 2);
                step(1, 1, 0, vecs[f].f3, 3'(k), vpc, vecs[f].taken_mask[k],
                     32'h3000, vpc);
            end
        end

        // Shadow: mispredicting branch right behind a mispredict is ignored
        step(1, 1, 0, F3_BNE, 3'b000, 32'h300, 0, 32'h380, 32'h300);
        step(1, 1, 0, F3_BEQ, 3'b100, 32'h304, 0, 32'h390, 32'h304);
        idle(32'h304);

        // Jump redirect and PC+4 wrap at the top of the address space
        step(1, 0, 1, 3'd0, 3'd0, 32'hFFFF_FFFC, 0, 32'h500, 32'hFFFF_FFFC);
        idle(32'hFFFF_FFFC);
        step(1, 1, 0, F3_BNE, 3'b100, 32'hFFFF_FFFC, 1, 32'h600, 32'hFFFF_FFFC);
        idle(32'hFFFF_FFFC);

        // Random traffic, including branch+jump together
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 3'($urandom), 3'($urandom), 32'($urandom_range(0, 127)) << 2,
                 1'($urandom), $urandom, 32'($urandom_range(0, 127)) << 2);
        end
        idle(32'h0);
        idle(32'h0);

        // Reset asserted during a redirect cycle drops everything
        step(1, 0, 1, 3'd0, 3'd0, 32'h700, 0, 32'h740, 32'h100);
        rst = 1'b1;
        bus.i_ex_valid = 1; bus.i_ex_branch = 1; bus.i_ex_funct3 = F3_BEQ;
        bus.i_ex_eq = 1; bus.i_ex_pred_taken = 0; bus.i_ex_pc = 32'h100;
        @(negedge clk);
        check("redirect_before_rst", {31'd0, bus.o_redirect_valid}, 32'd1);
        check("redirect_pc_before_rst", bus.o_redirect_pc, 32'h740);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(32'h100);
        idle(32'h40);

        // STAT_W=3 instance: nine spaced mispredicts saturate at 7
        for (int k = 0; k < 9; k++) begin
            bus2.i_ex_valid = 1;
            bus2.i_ex_pred_taken = 0;
            if (k == 0) begin
                bus2.i_ex_branch = 1; bus2.i_ex_jump = 0; bus2.i_ex_funct3 = F3_BEQ;
                bus2.i_ex_eq = 1; bus2.i_ex_pc = 32'h0; bus2.i_ex_target = 32'h40;
            end else begin
                bus2.i_ex_branch = 0; bus2.i_ex_jump = 1; bus2.i_ex_funct3 = 3'd0;
                bus2.i_ex_eq = 0; bus2.i_ex_pc = 32'h14; bus2.i_ex_target = 32'h80;
            end
            @(posedge clk);
            #1;
            check("s3_redirect_valid", {31'd0, bus2.o_redirect_valid}, 32'd1);
            check("s3_mp_count", {29'd0, bus2.o_mp_count}, (k + 1 > 7) ? 32'd7 : 32'(k + 1));
            bus2.i_ex_valid = 0;
            @(posedge clk);
            #1;
        end
        bus2.i_if_pc = 32'h0;
        #1;
        check("s3_br_count", {29'd0, bus2.o_br_count}, 32'd7);
        check("s3_mp_hold", {29'd0, bus2.o_mp_count}, 32'd7);
        check("s3_pred_trained", {31'd0, bus2.o_if_pred_taken}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch/jump resolution unit with a direction predictor. It sits between fetch and execute. Fetch gets a combinational taken/not-taken prediction from a table of 2-bit saturating counters. Execute resolves conditional branches from full comparison flags (eq/lt/ltu) and checks the outcome against the prediction carried down the pipe. On a mismatch it issues a registered one-cycle redirect/flush, trains the table, and keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- XLEN, 32, PC/target width
- BHT_ENTRIES, 64, predictor table depth; power of two, ≥2
- STAT_W, 32, statistics counter width

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_if_pc  in  XLEN  fetch PC used for the lookup
- o_if_pred_taken  out  1  combinational prediction, counter MSB at index i_if_pc[IDX+1:2], IDX = log2(BHT_ENTRIES)
- i_ex_valid  in  1  EX stage holds a valid instruction
- i_ex_branch  in  1  conditional branch
- i_ex_jump  in  1  JAL/JALR
- i_ex_funct3  in  3  branch condition
- i_ex_eq, i_ex_lt, i_ex_ltu  in  1 each  ALU comparison flags (rs1==rs2, signed <, unsigned <)
- i_ex_pc  in  XLEN  PC of the EX instruction
- i_ex_pred_taken  in  1  prediction made at fetch for this instruction
- i_ex_target  in  XLEN  taken target
- o_ex_taken  out  1  combinational resolved direction
- o_ex_illegal  out  1  combinational: branch with funct3 010/011
- o_redirect_valid  out  1  registered redirect/flush pulse
- o_redirect_pc  out  XLEN  registered redirect address
- o_br_count  out  STAT_W  resolved branches plus jumps
- o_mp_count  out  STAT_W  mispredicts

## Operation
- An EX instruction is accepted (acc) when i_ex_valid=1 and o_redirect_valid=0. While a redirect is being issued, the instruction in EX is wrong-path and is ignored.
- Direction, when acc and i_ex_branch=1:
  - funct3 000: eq
  - 001: ~eq
  - 100: lt
  - 101: ~lt
  - 110: ltu
  - 111: ~ltu
  - 010/011: not taken, o_ex_illegal=1
- When acc, i_ex_branch=0 and i_ex_jump=1: taken.
- Otherwise o_ex_taken=0.
- If i_ex_branch and i_ex_jump are both 1, branch takes priority.
- Mispredict = acc & (branch|jump) & (o_ex_taken != i_ex_pred_taken). An illegal branch counts as not taken.
- Table training applies only on acc & i_ex_branch & legal funct3, at index i_ex_pc[IDX+1:2]:
  - taken: saturating increment to 11
  - not taken: saturating decrement to 00
  - Jumps never train the table.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the MSB.
- Redirect target: taken ? i_ex_target : i_ex_pc+4, computed modulo 2^XLEN.
- Statistics, all saturating at 2^STAT_W-1 (no wrap):
  - o_br_count increments on acc & (branch|jump).
  - o_mp_count increments on a mispredict.

## Timing
- Reset values:
  - every table entry 01 (weak-NT)
  - o_redirect_valid=0, o_redirect_pc=0
  - o_br_count=0, o_mp_count=0
- o_if_pred_taken, o_ex_taken and o_ex_illegal are combinational with zero latency.
- Redirect: a mispredict resolved in cycle N gives o_redirect_valid=1 and o_redirect_pc valid in cycle N+1, for exactly one cycle. An EX instruction in cycle N+1 is ignored (no training, no count, no redirect). This guarantees no back-to-back redirects.
- The table update is visible to lookups from cycle N+1.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value; there is no bypass.
- Counters update at the edge ending cycle N.
- i_rst asserted mid-operation overrides everything at that edge: a pending redirect is dropped, and the table and counters are cleared.

## Structure
- Package branch_pkg holds:
  - funct3 constants: F3_BEQ..F3_BGEU
  - counter-state typedef bht_cnt_t (SNT/WNT/WT/ST)
  - saturating next-state functions sat_inc/sat_dec
- One sub-module, branch_history_table (params BHT_ENTRIES): one asynchronous read port, one synchronous write port, synchronous reset to WNT.
- The top level holds the resolve logic, redirect register and statistics.

## Test plan
- Reset, then lookup at any PC → o_if_pred_taken=0. BEQ at pc=0x100 with eq=1, pred=0 → cycle N+1: o_redirect_valid=1, o_redirect_pc=target, o_mp_count=1, o_br_count=1.
- Training: three taken BEQs at pc=0x40 with no intervening flush → entry goes 01→10→11→11, o_if_pred_taken(0x40)=1 after the first; one not-taken → 10, still predicts taken.
- All six funct3 with flag combinations (eq,lt,ltu) ∈ {0,1}³ → o_ex_taken matches the table above. funct3=010 → o_ex_illegal=1, taken=0, no training.
- Shadow: mispredict at N plus i_ex_valid mispredicting branch at N+1 → only one redirect pulse, o_mp_count=1.
- JAL with pred=0 at pc=0xFFFF_FFFC → redirect to i_ex_target. BNE not-taken with pred=1 at pc=0xFFFF_FFFC → redirect_pc=0x0000_0000 (wrap). Table unchanged for the JAL.
- STAT_W=3: nine mispredicts → o_mp_count holds 7. Assert i_rst during a redirect cycle → next cycle all outputs at reset values.
